// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared constants and state encoding for the pixel pipeline front end
// Contents: COORD_W/FRAC_W coordinate format, SPI_FRAME_BITS frame length,
//           rx_state_t receiver states IDLE/SHIFT/DRAIN.
package pipeline_pkg;

    localparam int COORD_W        = 32;
    localparam int FRAC_W         = 28;
    localparam int SPI_FRAME_BITS = 2 * COORD_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2
    } rx_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - multi-flop synchroniser with rise/fall pulse detection
// Ports: clk, nrst (sync active-low), din (async input),
//        level (synchronised level), rise/fall (one-clk pulses on level change).
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              hist;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            chain <= '0;
            hist  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            hist  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~hist;
    assign fall  = ~level & hist;

endmodule

// File: rtl/spi_coord_rx.sv
// rtl/spi_coord_rx.sv - SPI deserialiser producing one complex coordinate pair per frame
// Ports: clk, nrst (sync active-low); spi_clk/spi_en/spi_data (async SPI inputs);
//        out_ready (downstream accept); coord_re/coord_im (pair, raw Q4.28),
//        out_valid (pair held), overflow (sticky frame drop), busy (frame in progress).
module spi_coord_rx
    import pipeline_pkg::*;
#(
    parameter int WORD_W      = COORD_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              spi_clk,
    input  logic              spi_en,
    input  logic              spi_data,
    input  logic              out_ready,
    output logic [WORD_W-1:0] coord_re,
    output logic [WORD_W-1:0] coord_im,
    output logic              out_valid,
    output logic              overflow,
    output logic              busy
);

    localparam int FRAME_BITS = 2 * WORD_W;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    logic clk_rise;
    logic clk_level_unused;
    logic clk_fall_unused;
    logic en_level;
    logic en_rise;
    logic en_fall_unused;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_clk (
        .clk   (clk),
        .nrst  (nrst),
        .din   (spi_clk),
        .level (clk_level_unused),
        .rise  (clk_rise),
        .fall  (clk_fall_unused)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_en (
        .clk   (clk),
        .nrst  (nrst),
        .din   (spi_en),
        .level (en_level),
        .rise  (en_rise),
        .fall  (en_fall_unused)
    );

    // Same depth as the spi_clk chain so the data bit is aligned with the detected rise.
    logic [SYNC_STAGES-1:0] data_chain;
    logic                   data_level;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            data_chain <= '0;
        end else begin
            data_chain <= {data_chain[SYNC_STAGES-2:0], spi_data};
        end
    end

    assign data_level = data_chain[SYNC_STAGES-1];

    rx_state_t             state;
    logic [FRAME_BITS-1:0] sr;
    logic [CNT_W-1:0]      cnt;
    logic [FRAME_BITS-1:0] sr_next;

    assign sr_next = {sr[FRAME_BITS-2:0], data_level};

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            coord_re  <= '0;
            coord_im  <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // A handshake retires the pair; a commit below in the same cycle overrides this.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (en_rise) begin
                        cnt   <= '0;
                        sr    <= '0;
                        state <= SHIFT;
                        busy  <= 1'b1;
                    end
                end

                SHIFT: begin
                    // The final bit wins over a simultaneous spi_en drop.
                    if (clk_rise && cnt == LAST_BIT) begin
                        sr    <= sr_next;
                        cnt   <= cnt + 1'b1;
                        state <= DRAIN;
                        busy  <= 1'b0;
                        if (!out_valid || out_ready) begin
                            coord_re  <= sr_next[FRAME_BITS-1:WORD_W];
                            coord_im  <= sr_next[WORD_W-1:0];
                            out_valid <= 1'b1;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end else if (!en_level) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (clk_rise) begin
                        sr  <= sr_next;
                        cnt <= cnt + 1'b1;
                    end
                end

                DRAIN: begin
                    if (!en_level) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
